bpred_btb: RTL
==============

# bpred_btb

Parametrised branch target buffer with per-entry saturating counters for the 5-stage pipelined datapath. It replaces the single-bit `BranchPredictor` select with a real fetch-stage prediction of taken/not-taken and target, looked up on `PCF`. The table is trained from the Execute stage. Mispredict detection and the recovery PC for the Execute-stage PC mux are also computed here, and the block keeps branch and mispredict statistics.

## Interface
Parameters:
- `ENTRIES`, 16: table depth; power of two, 4..256.
- `CTR_W`, 2: saturating counter width, 1..4.
- `XLEN`, 32: address width.
- Derived, not overridable: `IDX_W` = log2(`ENTRIES`); `TAG_W` = `XLEN`-2-`IDX_W`.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `PCF` in XLEN: fetch PC.
- `PredHitF` out 1: valid entry with matching tag.
- `PredTakenF` out 1: predict taken.
- `PredTargetF` out XLEN: next fetch PC.
- `BranchE` in 1: a valid, unflushed branch is in Execute.
- `BranchTakenE` in 1: resolved direction.
- `BranchTargetE` in XLEN: resolved target.
- `PCE` in XLEN: PC of the branch in Execute.
- `PredTakenE` in 1: prediction made for it, carried down the pipe.
- `PredTargetE` in XLEN: prediction made for it, carried down the pipe.
- `MispredictE` out 1: redirect required.
- `RedirectPCE` out XLEN: correct next PC.
- `BranchCount` out 32: branches resolved.
- `MispredCount` out 32: mispredicts.

## Operation
**Entry contents:** `valid`, `tag[TAG_W]`, `target[XLEN]`, `ctr[CTR_W]`.

**Address fields:**
- index = `PC[IDX_W+1:2]`.
- tag = `PC[XLEN-1:IDX_W+2]`.
- `PC[1:0]` is ignored.

**Lookup (combinational on `PCF`):**
- `PredHitF` = valid & tag match.
- `PredTakenF` = `PredHitF` & `ctr[CTR_W-1]`.
- `PredTargetF` = `PredTakenF` ? target : `PCF`+4.

**Resolve (combinational, all outputs 0 when `BranchE`=0):**
- `MispredictE` = `BranchE` & ((`BranchTakenE` != `PredTakenE`) | (`BranchTakenE` & `BranchTargetE` != `PredTargetE`)).
- `RedirectPCE` = `BranchTakenE` ? `BranchTargetE` : `PCE`+4.

**Update (rising edge, only when `BranchE`=1), on the entry indexed by `PCE`:**
- Hit:
  - `ctr` increments if taken, decrements if not taken.
  - `ctr` saturates at all-ones and at 0; it never wraps.
  - If taken, `target` := `BranchTargetE`.
- Miss and taken: allocate (overwrite).
  - valid=1, tag from `PCE`, target=`BranchTargetE`.
  - ctr = weakly taken, i.e. 2^(CTR_W-1).
- Miss and not taken: table unchanged.

**Statistics:**
- `BranchCount` += 1 on every update.
- `MispredCount` += 1 when `MispredictE`.
- Both saturate at 0xFFFF_FFFF.

**Reset (asynchronous, takes effect immediately, including mid-update):**
- All valid bits = 0; all counters = weakly not-taken, 2^(CTR_W-1)-1 (0 when `CTR_W`=1).
- Tags and targets = 0; both statistics counters = 0.
- Outputs during reset follow the lookup rules: `PredHitF`=0, `PredTakenF`=0, `PredTargetF`=`PCF`+4.

## Timing
- Lookup has zero latency: pure combinational read of state, same cycle as `PCF`.
- Update becomes visible to lookups from the cycle after the `BranchE` edge.
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents; there is no bypass.
- `PredTakenE`/`PredTargetE` must be the values produced when that branch was in Fetch. The surrounding pipeline registers carry them; flushed branches must arrive with `BranchE`=0.
- The only state is the table and the two counters; there is no FSM.
- Implementation uses flip-flop arrays, no RAM macro, because the read is asynchronous.

## Structure
- `bpred_pkg` holds:
  - the counter constants `CTR_WEAK_T` and `CTR_WEAK_NT` as functions of `CTR_W`;
  - the `btb_entry_t` struct;
  - `idx_of()` and `tag_of()` helpers.
- One sub-module: `sat_counter` (width and enable parameters, increment-only, saturating), instantiated twice for the statistics counters.

## Test plan
All scenarios use `ENTRIES`=16, `CTR_W`=2.
1. Reset, then `PCF`=0x40 -> `PredHitF`=0, `PredTakenF`=0, `PredTargetF`=0x44, both counts 0.
2. `BranchE`=1, `PCE`=0x40, taken to 0x100, `PredTakenE`=0 -> `MispredictE`=1, `RedirectPCE`=0x100. Next cycle `PCF`=0x40 -> hit, taken, `PredTargetF`=0x100. `BranchCount`=1, `MispredCount`=1.
3. Counter walk at 0x40:
   - Two more taken -> ctr saturates at 3.
   - One not-taken -> still predicts taken.
   - Second not-taken -> ctr=1, `PredTakenF`=0, `PredTargetF`=0x44.
   - Three more not-taken -> ctr stays 0.
4. Alias: taken branch at `PCE`=0x80 to 0x200 (same index as 0x40) -> `PCF`=0x40 misses, `PCF`=0x80 hits with target 0x200.
5. Not-taken miss at `PCE`=0x48 with `PredTakenE`=0 -> `MispredictE`=0, `RedirectPCE`=0x4C, no allocation (`PCF`=0x48 still misses).
6. Target change:
   - Entry predicts 0x100; resolve taken to 0x180 with `PredTargetE`=0x100 -> `MispredictE`=1, and the entry target becomes 0x180.
   - Assert `reset` asynchronously mid-cycle -> hit drops immediately and both counts return to 0.

Source files
------------

// File: rtl/bpred_pkg.sv
// bpred_pkg: shared types, counter constants and PC field helpers for the branch target buffer.
package bpred_pkg;
    localparam int XLEN_MAX  = 64;
    localparam int CTR_W_MAX = 4;

    typedef logic [XLEN_MAX-1:0]  addr_t;
    typedef logic [CTR_W_MAX-1:0] ctr_t;

    // Fields are sized for the widest legal configuration; narrower builds zero-extend.
    typedef struct packed {
        logic  valid;
        addr_t tag;
        addr_t target;
        ctr_t  ctr;
    } btb_entry_t;

    function automatic ctr_t CTR_WEAK_T(input int w);
        return ctr_t'(1 << (w - 1));
    endfunction

    function automatic ctr_t CTR_WEAK_NT(input int w);
        return ctr_t'((1 << (w - 1)) - 1);
    endfunction

    function automatic addr_t idx_of(input addr_t pc, input int idx_w);
        return (pc >> 2) & ((addr_t'(1) << idx_w) - addr_t'(1));
    endfunction

    function automatic addr_t tag_of(input addr_t pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: increment-only counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            count <= '0;
        else if (en && count != '1)
            count <= count + 1'b1;
endmodule

// File: rtl/bpred_btb.sv
// bpred_btb: direct-mapped BTB with saturating direction counters, looked up on PCF and trained from Execute,
// plus mispredict detection, recovery PC and branch statistics.
module bpred_btb
    import bpred_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCF,
    output logic            PredHitF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic            BranchE,
    input  logic            BranchTakenE,
    input  logic [XLEN-1:0] BranchTargetE,
    input  logic [XLEN-1:0] PCE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    output logic            MispredictE,
    output logic [XLEN-1:0] RedirectPCE,
    output logic [31:0]     BranchCount,
    output logic [31:0]     MispredCount
);
    localparam int   IDX_W   = $clog2(ENTRIES);
    localparam int   TAG_W   = XLEN - 2 - IDX_W;
    localparam ctr_t CTR_MAX = ctr_t'((1 << CTR_W) - 1);

    btb_entry_t       tbl [ENTRIES];
    logic [IDX_W-1:0] idx_f, idx_e;
    addr_t            tag_f, tag_e;
    logic             hit_e;
    ctr_t             ctr_cur, ctr_nxt;

    assign idx_f = IDX_W'(idx_of(addr_t'(PCF), IDX_W));
    assign idx_e = IDX_W'(idx_of(addr_t'(PCE), IDX_W));
    assign tag_f = addr_t'(TAG_W'(tag_of(addr_t'(PCF), IDX_W)));
    assign tag_e = addr_t'(TAG_W'(tag_of(addr_t'(PCE), IDX_W)));

    assign PredHitF    = tbl[idx_f].valid && tbl[idx_f].tag == tag_f;
    assign PredTakenF  = PredHitF && tbl[idx_f].ctr[CTR_W-1];
    assign PredTargetF = PredTakenF ? XLEN'(tbl[idx_f].target) : PCF + XLEN'(4);

    assign MispredictE = BranchE && (BranchTakenE != PredTakenE || (BranchTakenE && BranchTargetE != PredTargetE));
    assign RedirectPCE = !BranchE ? '0 : BranchTakenE ? BranchTargetE : PCE + XLEN'(4);

    assign hit_e = tbl[idx_e].valid && tbl[idx_e].tag == tag_e;

    always_comb begin
        ctr_cur = tbl[idx_e].ctr;
        ctr_nxt = BranchTakenE ? (ctr_cur == CTR_MAX ? ctr_cur : ctr_cur + 1'b1)
                               : (ctr_cur == '0 ? ctr_cur : ctr_cur - 1'b1);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT(CTR_W)};
        end else if (BranchE) begin
            if (hit_e) begin
                tbl[idx_e].ctr <= ctr_nxt;
                if (BranchTakenE)
                    tbl[idx_e].target <= addr_t'(BranchTargetE);
            end else if (BranchTakenE) begin
                // Miss-taken always evicts whatever shares the index.
                tbl[idx_e] <= '{valid: 1'b1, tag: tag_e, target: addr_t'(BranchTargetE), ctr: CTR_WEAK_T(CTR_W)};
            end
        end

    sat_counter #(.W(32)) u_branch_count (.clk(clk), .reset(reset), .en(BranchE),     .count(BranchCount));
    sat_counter #(.W(32)) u_mispred_count (.clk(clk), .reset(reset), .en(MispredictE), .count(MispredCount));
endmodule
